// File: rtl/piece_collision_scanner.sv
// Walks the 4x4 block-local grid of a tetromino and checks every occupied cell
// against the playfield bounds and occupancy RAM, producing collision flags.
module piece_collision_scanner #(
  parameter int FIELD_W = 20,
  parameter int FIELD_H = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  pos_x,
  input  logic [4:0]  pos_y,
  input  logic [9:0]  rotate,
  input  logic [15:0] shape,
  output logic [4:0]  ix_pos_x,
  output logic [4:0]  ix_pos_y,
  output logic [9:0]  ix_rotate,
  output logic [4:0]  ix_b_x,
  output logic [4:0]  ix_b_y,
  input  logic [4:0]  ix_block_index,
  input  logic [8:0]  ix_field_index,
  output logic        field_rd_en,
  output logic [8:0]  field_addr,
  input  logic        field_rd_data,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic        out_of_bounds
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [5:0] FW = 6'(FIELD_W);
  localparam logic [5:0] FH = 6'(FIELD_H);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [15:0] shape_q;
  logic        pend;
  logic [8:0]  addr_q;
  logic [5:0]  fx, fy;
  logic        occ, inb;

  assign ix_b_x = {3'b000, cnt[1:0]};
  assign ix_b_y = {3'b000, cnt[3:2]};

  // Field coordinates are computed one bit wider so origins near the edge cannot wrap back in bounds.
  always_comb begin
    fx  = {1'b0, ix_pos_x} + {4'b0000, cnt[1:0]};
    fy  = {1'b0, ix_pos_y} + {4'b0000, cnt[3:2]};
    inb = (fx < FW) && (fy < FH);
    occ = (ix_block_index < 5'd16) && shape_q[ix_block_index[3:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (cnt == 4'd15) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The address is held between reads so the RAM port sees no spurious toggling.
  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    field_rd_en = (state == SCAN) && occ && inb;
    field_addr  = field_rd_en ? ix_field_index : addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ix_pos_x      <= '0;
      ix_pos_y      <= '0;
      ix_rotate     <= '0;
      shape_q       <= '0;
      cnt           <= '0;
      pend          <= 1'b0;
      addr_q        <= '0;
      collision     <= 1'b0;
      out_of_bounds <= 1'b0;
    end else begin
      addr_q <= field_addr;
      case (state)
        IDLE: begin
          if (start) begin
            ix_pos_x      <= pos_x;
            ix_pos_y      <= pos_y;
            ix_rotate     <= rotate;
            shape_q       <= shape;
            cnt           <= '0;
            pend          <= 1'b0;
            collision     <= 1'b0;
            out_of_bounds <= 1'b0;
          end
        end
        SCAN: begin
          cnt  <= cnt + 4'd1;
          pend <= occ && inb;
          if (occ && !inb) begin
            collision     <= 1'b1;
            out_of_bounds <= 1'b1;
          end
          if (pend && field_rd_data) collision <= 1'b1;
        end
        DRAIN: begin
          pend <= 1'b0;
          if (pend && field_rd_data) collision <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_collision_scanner.sv
// Scoreboard bench for piece_collision_scanner with a mapper model, a playfield RAM
// model and a grid-rotation reference model.
module tb_piece_collision_scanner;

  localparam int FW = 20;
  localparam int FH = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  pos_x = '0, pos_y = '0;
  logic [9:0]  rotate = '0;
  logic [15:0] shape = '0;
  logic [4:0]  ix_pos_x, ix_pos_y, ix_b_x, ix_b_y;
  logic [9:0]  ix_rotate;
  logic [4:0]  ix_block_index;
  logic [8:0]  ix_field_index;
  logic        field_rd_en;
  logic [8:0]  field_addr;
  logic        field_rd_data = 1'b0;
  logic        busy, done, collision, out_of_bounds;

  piece_collision_scanner #(.FIELD_W(FW), .FIELD_H(FH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pos_x(pos_x), .pos_y(pos_y), .rotate(rotate), .shape(shape),
    .ix_pos_x(ix_pos_x), .ix_pos_y(ix_pos_y), .ix_rotate(ix_rotate),
    .ix_b_x(ix_b_x), .ix_b_y(ix_b_y),
    .ix_block_index(ix_block_index), .ix_field_index(ix_field_index),
    .field_rd_en(field_rd_en), .field_addr(field_addr), .field_rd_data(field_rd_data),
    .busy(busy), .done(done), .collision(collision), .out_of_bounds(out_of_bounds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic coll;
    logic oob;
    int   done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   rd_q[$];
  logic field [FW*FH];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_addr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Mapper: rotation r shows source cell (sx,sy) at displayed cell (bx,by), clockwise.
  always_comb begin
    case (ix_rotate[1:0])
      2'd0: ix_block_index = 5'(ix_b_y * 4 + ix_b_x);
      2'd1: ix_block_index = 5'((3 - ix_b_x) * 4 + ix_b_y);
      2'd2: ix_block_index = 5'((3 - ix_b_y) * 4 + (3 - ix_b_x));
      default: ix_block_index = 5'(ix_b_x * 4 + (3 - ix_b_y));
    endcase
    ix_field_index = 9'((32'(ix_pos_y) + 32'(ix_b_y)) * FW + 32'(ix_pos_x) + 32'(ix_b_x));
  end

  always @(posedge clk)
    if (field_rd_en) field_rd_data <= (int'(field_addr) < FW*FH) ? field[field_addr] : 1'b0;

  task automatic checkOutput(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: rotate the 4x4 grid as a picture, then visit cells in scan order.
  task automatic computeModel(input logic [15:0] shp, input logic [9:0] rot,
                              input int px, input int py, input int done_cyc);
    logic g[4][4];
    logic t[4][4];
    exp_t e;
    e.coll = 1'b0;
    e.oob = 1'b0;
    e.done_cyc = done_cyc;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) g[x][y] = shp[y*4+x];
    for (int r = 0; r < int'(rot % 4); r++) begin
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++) t[x][y] = g[y][3-x];
      g = t;
    end
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        if (g[x][y]) begin
          if (px + x < FW && py + y < FH) begin
            rd_q.push_back((py + y) * FW + px + x);
            if (field[(py + y) * FW + px + x]) e.coll = 1'b1;
          end else begin
            e.coll = 1'b1;
            e.oob = 1'b1;
          end
        end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_addr = 0;
    end else begin
      if (field_rd_en) begin
        if (rd_q.size() == 0) checkOutput("unexpected_read", int'(field_addr), -1);
        else checkOutput("read_addr", int'(field_addr), rd_q.pop_front());
        last_addr = int'(field_addr);
      end else begin
        checkOutput("addr_hold", int'(field_addr), last_addr);
      end
      if (done) begin
        if (exp_q.size() == 0) checkOutput("spurious_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("done_cycle", cyc, e.done_cyc);
          checkOutput("collision", int'(collision), int'(e.coll));
          checkOutput("out_of_bounds", int'(out_of_bounds), int'(e.oob));
          checkOutput("reads_left", rd_q.size(), 0);
        end
      end
    end
  end

  task automatic scramble();
    pos_x = 5'($urandom);
    pos_y = 5'($urandom);
    rotate = 10'($urandom);
    shape = 16'($urandom);
  endtask

  // Issues a start from IDLE and returns just after the accepting edge.
  task automatic applyStimulus(input logic [15:0] shp, input logic [9:0] rot,
                               input logic [4:0] px, input logic [4:0] py);
    @(negedge clk);
    shape = shp; rotate = rot; pos_x = px; pos_y = py; start = 1'b1;
    computeModel(shp, rot, int'(px), int'(py), cyc + 18);
    @(posedge clk);
    #1;
    checkOutput("busy_after_start", int'(busy), 1);
    start = 1'b0;
    scramble();
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("done_timeout", 0, 1);
      exp_q.delete();
      rd_q.delete();
    end
    @(posedge clk);
    #1;
    checkOutput("idle_after_done", int'(busy), 0);
  endtask

  task automatic clearField();
    for (int i = 0; i < FW*FH; i++) field[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clearField();
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_rd_en", int'(field_rd_en), 0);
    checkOutput("rst_addr", int'(field_addr), 0);
    checkOutput("rst_coll", int'(collision), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h0066, 10'd0, 5'd0, 5'd0);
    waitDone();
    field[22] = 1'b1;
    applyStimulus(16'h0066, 10'd0, 5'd0, 5'd0);
    waitDone();
    clearField();
    applyStimulus(16'h000F, 10'd0, 5'd18, 5'd0);
    waitDone();
    field[45] = 1'b1;
    applyStimulus(16'h0001, 10'd0, 5'd3, 5'd2);
    waitDone();
    clearField();
    field[0] = 1'b1;
    applyStimulus(16'h1000, 10'd5, 5'd0, 5'd0);
    waitDone();
    applyStimulus(16'h0000, 10'd0, 5'd30, 5'd30);
    waitDone();

    // A start pulse mid-scan must not queue a second scan.
    applyStimulus(16'h0033, 10'd2, 5'd19, 5'd22);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone();

    // Start held through the DONE cycle is taken only from the following IDLE cycle.
    field[0] = 1'b1;
    applyStimulus(16'h0001, 10'd0, 5'd0, 5'd0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      #1;
    end
    shape = 16'h0001; rotate = 10'd0; pos_x = 5'd0; pos_y = 5'd0; start = 1'b1;
    computeModel(16'h0001, 10'd0, 0, 0, cyc + 19);
    @(posedge clk);
    #1;
    checkOutput("done_cycle_start_ignored", int'(busy), 0);
    @(posedge clk);
    #1;
    checkOutput("busy_after_late_start", int'(busy), 1);
    start = 1'b0;
    waitDone();

    // Reset mid-scan aborts without a done pulse.
    applyStimulus(16'hFFFF, 10'd0, 5'd17, 5'd21);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    rd_q.delete();
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_coll", int'(collision), 0);
    checkOutput("midrst_oob", int'(out_of_bounds), 0);
    checkOutput("midrst_rd_en", int'(field_rd_en), 0);
    checkOutput("midrst_pos_x", int'(ix_pos_x), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(16'h0066, 10'd1, 5'd10, 5'd10);
    waitDone();

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < FW*FH; i++) field[i] = ($urandom_range(0, 5) == 0);
      applyStimulus(16'($urandom), 10'($urandom),
                    5'($urandom_range(0, 22)), 5'($urandom_range(0, 26)));
      waitDone();
    end

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
